// File: rtl/id_ex_skid_stage.sv
// Decode->execute pipeline register with a two-entry skid buffer, flush-to-bubble
// and a saturating stall counter. Any non-valid output slot carries CTRL_NOP.
module id_ex_skid_stage #(
   parameter int                 DATA_W   = 256,
   parameter int                 CTRL_W   = 8,
   parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
   parameter int                 CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Handshake: a beat moves when valid && ready are both high at a clock edge;
   // valid never waits on ready, and in_ready looks only at held state and flush.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   main_data, main_data_nxt;
   logic [CTRL_W-1:0]   main_ctrl, main_ctrl_nxt;
   logic [DATA_W-1:0]   skid_data, skid_data_nxt;
   logic [CTRL_W-1:0]   skid_ctrl, skid_ctrl_nxt;
   logic                acc, pop;

   assign in_ready  = (state != FULL) && !flush;
   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = main_data;
   assign out_ctrl  = main_ctrl;

   always_comb begin
      state_nxt     = state;
      main_data_nxt = main_data;
      main_ctrl_nxt = main_ctrl;
      skid_data_nxt = skid_data;
      skid_ctrl_nxt = skid_ctrl;
      case (state)
         EMPTY: begin
            if (acc) begin
               state_nxt     = ONE;
               main_data_nxt = in_data;
               main_ctrl_nxt = in_ctrl;
            end
         end
         ONE: begin
            if (acc && !pop) begin
               state_nxt     = FULL;
               skid_data_nxt = in_data;
               skid_ctrl_nxt = in_ctrl;
            end else if (pop && !acc) begin
               state_nxt = EMPTY;
            end else if (acc && pop) begin
               main_data_nxt = in_data;
               main_ctrl_nxt = in_ctrl;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt     = ONE;
               main_data_nxt = skid_data;
               main_ctrl_nxt = skid_ctrl;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush drops everything but leaves out_data frozen rather than advancing it.
      if (flush) begin
         state_nxt     = EMPTY;
         main_data_nxt = main_data;
      end
      if (state_nxt == EMPTY) main_ctrl_nxt = CTRL_NOP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         main_data <= '0;
         main_ctrl <= CTRL_NOP;
         skid_data <= '0;
         skid_ctrl <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
         main_data <= main_data_nxt;
         main_ctrl <= main_ctrl_nxt;
         skid_data <= skid_data_nxt;
         skid_ctrl <= skid_ctrl_nxt;
         if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: reset, streaming, back-pressure, flush,
// accept+pop overlap, stall counter saturation and reset-over-flush priority.
module tb_id_ex_skid_stage;

   localparam int         DATA_W   = 32;
   localparam int         CTRL_W   = 8;
   localparam logic [7:0] NOP      = 8'hEE;
   localparam int         CNT_W    = 4;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   int vectors = 0;
   int fails   = 0;
   int exp_stall = 0;

   id_ex_skid_stage #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(NOP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs, check in_ready, then advance to the next negedge.
   task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl, input logic exp_rdy);
      in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
      #1;
      vectors++;
      assert (in_ready === exp_rdy) else begin
         fails++;
         $error("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
      end
      if (v && !exp_rdy && exp_stall < 15) exp_stall++;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic ev, input logic [31:0] ed,
                      input logic [7:0] ec);
      vectors++;
      assert (out_valid === ev) else begin
         fails++;
         $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, ev);
      end
      vectors++;
      assert (out_data === ed) else begin
         fails++;
         $error("FAIL %s out_data: got %h expected %h", tag, out_data, ed);
      end
      vectors++;
      assert (out_ctrl === ec) else begin
         fails++;
         $error("FAIL %s out_ctrl: got %h expected %h", tag, out_ctrl, ec);
      end
      vectors++;
      assert (stall_cnt === CNT_W'(exp_stall)) else begin
         fails++;
         $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, exp_stall);
      end
   endtask

   initial begin
      // Reset for two cycles with a beat offered
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h03;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_stall = 0;
      chk("reset", 1'b0, 32'h0, NOP);
      reset = 1'b0;
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("post_reset", 1'b0, 32'h0, NOP);

      // Streaming at full rate
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'(i), 8'(i + 1), 1'b1, 1'b0, 1'b1);
         chk("stream", 1'b1, 32'(i), 8'(i + 1));
      end
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("stream_drain", 1'b0, 32'd9, NOP);

      // Back-pressure: A, B accepted, C blocked until release
      step(1'b1, 32'hA, 8'h1A, 1'b0, 1'b0, 1'b1);
      chk("bp_a", 1'b1, 32'hA, 8'h1A);
      step(1'b1, 32'hB, 8'h1B, 1'b0, 1'b0, 1'b1);
      chk("bp_full", 1'b1, 32'hA, 8'h1A);
      step(1'b1, 32'hC, 8'h1C, 1'b0, 1'b0, 1'b0);
      chk("bp_block1", 1'b1, 32'hA, 8'h1A);
      step(1'b1, 32'hC, 8'h1C, 1'b0, 1'b0, 1'b0);
      chk("bp_block2", 1'b1, 32'hA, 8'h1A);
      step(1'b1, 32'hC, 8'h1C, 1'b1, 1'b0, 1'b0);
      chk("bp_pop_b", 1'b1, 32'hB, 8'h1B);
      step(1'b1, 32'hC, 8'h1C, 1'b1, 1'b0, 1'b1);
      chk("bp_pop_c", 1'b1, 32'hC, 8'h1C);
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("bp_drain", 1'b0, 32'hC, NOP);

      // Flush while FULL with C offered
      step(1'b1, 32'hA2, 8'h2A, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hB2, 8'h2B, 1'b0, 1'b0, 1'b1);
      chk("fl_full", 1'b1, 32'hA2, 8'h2A);
      step(1'b1, 32'hC2, 8'h2C, 1'b0, 1'b1, 1'b0);
      chk("fl_bubble", 1'b0, 32'hA2, NOP);
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("fl_empty", 1'b0, 32'hA2, NOP);
      step(1'b1, 32'hD2, 8'h2D, 1'b1, 1'b0, 1'b1);
      chk("fl_d", 1'b1, 32'hD2, 8'h2D);
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("fl_drain", 1'b0, 32'hD2, NOP);

      // Simultaneous accept and pop in ONE
      step(1'b1, 32'hE0, 8'h40, 1'b1, 1'b0, 1'b1);
      chk("ovl_0", 1'b1, 32'hE0, 8'h40);
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 32'hE0 + 32'(k), 8'h40 + 8'(k), 1'b1, 1'b0, 1'b1);
         chk("ovl", 1'b1, 32'hE0 + 32'(k), 8'h40 + 8'(k));
      end
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b1);
      chk("ovl_drain", 1'b0, 32'hE5, NOP);

      // Saturation: 30 cycles offered with out_ready low
      for (int j = 0; j < 30; j++)
         step(1'b1, 32'h50 + 32'(j), 8'h50 + 8'(j), 1'b0, 1'b0, (j < 2));
      chk("sat", 1'b1, 32'h50, 8'h50);
      vectors++;
      assert (stall_cnt === 4'd15) else begin
         fails++;
         $error("FAIL sat_cap stall_cnt: got %0d expected 15", stall_cnt);
      end

      // Reset wins over a concurrent flush
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0; flush = 1'b0;
      exp_stall = 0;
      chk("rst_over_flush", 1'b0, 32'h0, NOP);
      step(1'b1, 32'h99, 8'h09, 1'b1, 1'b0, 1'b1);
      chk("after_rst", 1'b1, 32'h99, 8'h09);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
